// File: rtl/resize_interp_acc_if.sv
// Handshake bundle for resize_interp_acc: weighted-product input stream
// and rounded/saturated pixel output stream.
interface resize_interp_acc_if #(
   parameter int OUT_W = 8
);
   logic [23:0]      in_data;
   logic             in_valid;
   logic             in_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_sat;
   logic             out_valid;
   logic             out_ready;

   // upstream producer / downstream consumer side
   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_sat,
      input  out_valid,
      output out_ready
   );

   // accumulator side
   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_sat,
      output out_valid,
      input  out_ready
   );
endinterface

// File: rtl/resize_interp_acc.sv
// Resize interpolation accumulator: sums TAPS weighted products, rounds
// half-up, drops the SHIFT weight fraction bits and saturates to OUT_W.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACC   | accepting taps; acc/tap hold through input gaps
// HOLD  | result presented on out_*; input stalled until out_ready
module resize_interp_acc #(
   parameter int TAPS  = 4,
   parameter int SHIFT = 16,
   parameter int OUT_W = 8
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   resize_interp_acc_if.slave bus
);
   localparam int TAP_W = $clog2(TAPS);
   localparam int ACC_W = 24 + TAP_W + 1;
   // one extra bit so the rounding constant can never wrap the final sum
   localparam int SUM_W = ACC_W + 1;
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
   localparam logic [SUM_W-1:0] RND      = SUM_W'(64'd1 << (SHIFT - 1));
   localparam logic [SUM_W-1:0] MAX_Q    = SUM_W'((64'd1 << OUT_W) - 64'd1);

   typedef enum logic {ST_ACC, ST_HOLD} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [TAP_W-1:0] tap;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_base;
   logic [SUM_W-1:0] sum;
   logic [SUM_W-1:0] q;
   logic             in_xfer;
   logic             out_xfer;
   logic             last_tap;
   logic             q_over;

   assign in_xfer  = bus.in_valid && bus.in_ready;
   assign out_xfer = bus.out_valid && bus.out_ready;
   assign last_tap = (tap == LAST_TAP);
   // tap 0 restarts the sum, so no explicit clear of acc is needed
   assign acc_base = (tap == '0) ? '0 : acc;
   assign sum      = SUM_W'(acc_base) + SUM_W'(bus.in_data) + RND;
   assign q        = sum >> SHIFT;
   assign q_over   = (q > MAX_Q);

   // state register
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) state <= ST_ACC;
      else           state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_ACC:  if (in_xfer && last_tap) state_nxt = ST_HOLD;
         ST_HOLD: if (out_xfer)            state_nxt = ST_ACC;
         default:                          state_nxt = ST_ACC;
      endcase
   end

   // input acceptance; held low while reset is asserted
   always_comb begin
      bus.in_ready = ap_rst_n && (state == ST_ACC);
   end

   // tap counter and running sum
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         tap <= '0;
         acc <= '0;
      end else if (in_xfer) begin
         if (last_tap) begin
            tap <= '0;
         end else begin
            acc <= acc_base + ACC_W'(bus.in_data);
            tap <= tap + TAP_W'(1);
         end
      end
   end

   // output pixel register, loaded on the last tap and held until taken
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sat   <= 1'b0;
      end else if (in_xfer && last_tap) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= q_over ? {OUT_W{1'b1}} : q[OUT_W-1:0];
         bus.out_sat   <= q_over;
      end else if (out_xfer) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: doc/resize_interp_acc.md
RESIZE_INTERP_ACC -- requirements
Module: resize_interp_acc

Interface
REQ-001 The block SHALL have parameter TAPS, default 4, meaning products summed per output pixel (legal range 2..16).
REQ-002 The block SHALL have parameter SHIFT, default 16, meaning the right-shift that removes the weight fraction bits (legal range 1..23).
REQ-003 The block SHALL have parameter OUT_W, default 8, meaning the output pixel width.
REQ-004 The block SHALL have port ap_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port ap_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port in_data, input, 24 bits: unsigned weighted product from the upstream 16x8 multiplier.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 The block SHALL have port out_data, output, OUT_W bits: the rounded, saturated pixel.
REQ-010 The block SHALL have port out_sat, output, 1 bit: out_data was clipped to its maximum.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data and out_sat are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output.

Function
REQ-013 A transfer SHALL occur on a cycle where valid and ready are both high, on either side.
REQ-014 The FSM SHALL have two states, ACC and HOLD; in_ready SHALL equal (state==ACC).
REQ-015 The accumulator SHALL be ACC_W = 24 + clog2(TAPS) + 1 bits wide and unsigned; no intermediate truncation is allowed.
REQ-016 The tap counter SHALL be clog2(TAPS) bits, counting 0..TAPS-1.
REQ-017 ACC, input transfer with tap<TAPS-1: acc <= acc + in_data (acc <= in_data when tap==0); tap <= tap+1.
REQ-018 ACC, input transfer with tap==TAPS-1: sum = acc + in_data + 2^(SHIFT-1); q = sum >> SHIFT.
  - out_data <= min(q, 2^OUT_W-1); out_sat <= (q > 2^OUT_W-1).
  - out_valid <= 1; tap <= 0; state <= HOLD.
REQ-019 Latency SHALL be 1 cycle: out_valid is high the cycle after the last tap transfer.
REQ-020 HOLD: out_data, out_sat and out_valid SHALL remain stable until out_ready is high.
  - On an output transfer: out_valid <= 0; state <= ACC.
REQ-021 in_ready SHALL be low throughout HOLD; input offered during HOLD SHALL NOT be consumed or lost.
REQ-022 Sustained throughput SHALL be one pixel per TAPS+1 cycles when out_ready is held high.
REQ-023 In ACC with in_valid low, acc and tap SHALL hold their values; gaps between taps SHALL NOT affect the result.
REQ-024 Rounding SHALL be round-half-up.
REQ-025 The arithmetic SHALL be exact for all inputs, including all-ones taps (no accumulator wrap).
REQ-026 out_data and out_sat SHALL hold their last value while out_valid is low.

Reset
REQ-027 When ap_rst_n is low at a clock edge, the block SHALL set:
  - state=ACC, tap=0, acc=0;
  - out_valid=0, out_data=0, out_sat=0.
REQ-028 in_ready SHALL be 0 during reset and SHALL be 1 in the first cycle after reset release.
REQ-029 Reset mid-accumulation or in HOLD SHALL discard the partial sum or pending pixel; the next pixel starts at tap 0.

Verification
REQ-030 Four taps of 0x100000, out_ready=1 -> out_data=0x40, out_sat=0, out_valid exactly 1 cycle after the 4th transfer.
REQ-031 Rounding: taps 0x008000,0,0,0 -> out_data=0x01; taps 0x007FFF,0,0,0 -> out_data=0x00.
REQ-032 Saturation: four taps of 0x400000 -> out_data=0xFF, out_sat=1; four taps of 0xFFFFFF -> out_data=0xFF, out_sat=1 (no wrap).
REQ-033 Backpressure: out_ready held low 5 cycles after a result -> out_valid, out_data stable, in_ready=0, and next-pixel taps stalled but intact; the following pixel is correct.
REQ-034 Reset: assert ap_rst_n=0 after 2 of 4 taps, then release and send four taps of 0x010000 -> out_data=0x04; the stale partial sum is absent.
REQ-035 Random valid/ready gaps, 1000 pixels -> every output matches a reference model of REQ-018.
